// File: rtl/fp_addsub_seq.sv
// fp_addsub_seq -- multi-cycle floating-point add/subtract unit with a
// start/done handshake, meant as a shared arithmetic slave.
//
// Operands are packed {sign, exp, frac}. Exponent 0 means zero, and any
// fraction bits are ignored. An all-ones exponent is treated as an ordinary
// exponent; there is no NaN/Inf decode. Exponents are aligned with one
// right shift per cycle. The magnitudes are then added or subtracted,
// normalised with one shift per cycle, and repacked.
//
// Optional feature macro: ROUND_NEAREST_EN
//   defined   : guard/round/sticky bits are carried and PACK rounds to
//               nearest, ties to even
//   undefined : one extension bit is carried and PACK truncates toward zero
//
// Parameters: EXP_W exponent width (bias 2^(EXP_W-1)-1), FRAC_W stored fraction width
// Ports:
//   clk       clock, rising edge
//   rst       synchronous reset, active high
//   start     request, sampled only in IDLE
//   op        0 = a+b, 1 = a-b
//   a, b      packed operands
//   busy      high from the cycle after accept until done
//   done      one-cycle pulse, result valid
//   result    packed result, held until overwritten by the next operation
//   overflow  result saturated to infinity (held with result)
//   underflow result flushed to zero (held with result)
//
// state | meaning
// IDLE  | waiting for start
// ALIGN | shift the smaller-exponent mantissa right until the exponents match
// ADD   | signed-magnitude add/subtract
// NORM  | one normalising shift per cycle, plus the zero/overflow/underflow exits
// PACK  | round (if enabled) and write the packed result
// DONE  | done pulse
module fp_addsub_seq #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  op,
    input  logic [EXP_W+FRAC_W:0] a,
    input  logic [EXP_W+FRAC_W:0] b,
    output logic                  busy,
    output logic                  done,
    output logic [EXP_W+FRAC_W:0] result,
    output logic                  overflow,
    output logic                  underflow
);
`ifdef ROUND_NEAREST_EN
    localparam int XB = 3;
`else
    localparam int XB = 1;
`endif
    localparam int W  = 1 + EXP_W + FRAC_W;
    // Mantissa layout: carry | hidden | fraction | extension bits
    localparam int MW = 2 + FRAC_W + XB;

    localparam logic [EXP_W-1:0] E_MAX    = '1;
    localparam logic [EXP_W-1:0] E_MAX_M1 = E_MAX - 1'b1;
    localparam logic [EXP_W-1:0] E_ONE    = EXP_W'(1);
    localparam logic [EXP_W-1:0] FAR_LIM  = EXP_W'(FRAC_W + 3);

    typedef enum logic [2:0] {
        S_IDLE, S_ALIGN, S_ADD, S_NORM, S_PACK, S_DONE
    } state_t;

    state_t state, state_nxt;

    logic             sa, sb, sr;
    logic [EXP_W-1:0] ea, eb, er, er_inc;
    logic [MW-1:0]    ma, mb, mr;

    // One-bit right shift. With rounding enabled, bit 0 is sticky and
    // collects every 1 that is shifted out.
    function automatic logic [MW-1:0] shr1(input logic [MW-1:0] m);
`ifdef ROUND_NEAREST_EN
        return {1'b0, m[MW-1:2], m[1] | m[0]};
`else
        return {1'b0, m[MW-1:1]};
`endif
    endfunction

    // Early-exit alignment: the smaller operand disappears entirely.
    function automatic logic [MW-1:0] far_drop(input logic [MW-1:0] m);
`ifdef ROUND_NEAREST_EN
        return {{(MW-1){1'b0}}, |m};
`else
        return (m == '0) ? '0 : '0;
`endif
    endfunction

    logic [EXP_W-1:0] e_diff;
    logic             a_lt_b, b_lt_a, far;

    assign a_lt_b = ea < eb;
    assign b_lt_a = eb < ea;
    assign e_diff = a_lt_b ? (eb - ea) : (ea - eb);
    assign far    = e_diff > FAR_LIM;
    assign er_inc = er + 1'b1;

    // Rounded {carry, hidden, fraction}.
    logic              round_up;
    logic [FRAC_W+1:0] rnd_m;

`ifdef ROUND_NEAREST_EN
    assign round_up = mr[2] & (mr[1] | mr[0] | mr[3]);
`else
    assign round_up = 1'b0;
`endif
    assign rnd_m = {1'b0, mr[MW-2 -: FRAC_W+1]} + (FRAC_W+2)'(round_up);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE:  if (start) state_nxt = S_ALIGN;
            S_ALIGN: begin
                busy = 1'b1;
                if (ea == eb) state_nxt = S_ADD;
            end
            S_ADD: begin
                busy      = 1'b1;
                state_nxt = S_NORM;
            end
            S_NORM: begin
                busy = 1'b1;
                if (mr == '0)            state_nxt = S_DONE;
                else if (mr[MW-1])       begin if (er >= E_MAX_M1) state_nxt = S_DONE; end
                else if (!mr[MW-2])      begin if (er <= E_ONE) state_nxt = S_DONE; end
                else                     state_nxt = S_PACK;
            end
            S_PACK: begin
                busy      = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sa <= 1'b0; sb <= 1'b0; sr <= 1'b0;
            ea <= '0;   eb <= '0;   er <= '0;
            ma <= '0;   mb <= '0;   mr <= '0;
            result    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    sa <= a[W-1];
                    sb <= b[W-1] ^ op;
                    ea <= a[W-2 -: EXP_W];
                    eb <= b[W-2 -: EXP_W];
                    ma <= (a[W-2 -: EXP_W] == '0) ? '0 : {2'b01, a[FRAC_W-1:0], {XB{1'b0}}};
                    mb <= (b[W-2 -: EXP_W] == '0) ? '0 : {2'b01, b[FRAC_W-1:0], {XB{1'b0}}};
                end
                S_ALIGN: begin
                    if (a_lt_b) begin
                        if (far) begin ma <= far_drop(ma); ea <= eb; end
                        else     begin ma <= shr1(ma);     ea <= ea + 1'b1; end
                    end else if (b_lt_a) begin
                        if (far) begin mb <= far_drop(mb); eb <= ea; end
                        else     begin mb <= shr1(mb);     eb <= eb + 1'b1; end
                    end
                end
                S_ADD: begin
                    er <= ea;
                    if (sa == sb)   begin mr <= ma + mb; sr <= sa;   end
                    else if (ma > mb) begin mr <= ma - mb; sr <= sa; end
                    else if (mb > ma) begin mr <= mb - ma; sr <= sb; end
                    else            begin mr <= '0;      sr <= 1'b0; end
                end
                S_NORM: begin
                    if (mr == '0) begin
                        // -0 survives only when both operands were negative
                        result    <= {sa & sb, {(W-1){1'b0}}};
                        overflow  <= 1'b0;
                        underflow <= 1'b0;
                    end else if (mr[MW-1]) begin
                        if (er >= E_MAX_M1) begin
                            result    <= {sr, E_MAX, {FRAC_W{1'b0}}};
                            overflow  <= 1'b1;
                            underflow <= 1'b0;
                        end else begin
                            mr <= shr1(mr);
                            er <= er_inc;
                        end
                    end else if (!mr[MW-2]) begin
                        if (er > E_ONE) begin
                            mr <= {mr[MW-2:0], 1'b0};
                            er <= er - 1'b1;
                        end else begin
                            result    <= '0;
                            overflow  <= 1'b0;
                            underflow <= 1'b1;
                        end
                    end
                end
                S_PACK: begin
                    underflow <= 1'b0;
                    if (rnd_m[FRAC_W+1]) begin
                        // rounding carried out: mantissa is now exactly 1.0
                        if (er >= E_MAX_M1) begin
                            result   <= {sr, E_MAX, {FRAC_W{1'b0}}};
                            overflow <= 1'b1;
                        end else begin
                            result   <= {sr, er_inc, {FRAC_W{1'b0}}};
                            overflow <= 1'b0;
                        end
                    end else begin
                        result   <= {sr, er, rnd_m[FRAC_W-1:0]};
                        overflow <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_addsub_seq.sv
`timescale 1ns/1ps
module tb_fp_addsub_seq;

`ifdef ROUND_NEAREST_EN
    localparam int  XB = 3;
    localparam bit  RN = 1'b1;
    localparam logic [31:0] T3_LIT = 32'h4B80_0002;
`else
    localparam int  XB = 1;
    localparam bit  RN = 1'b0;
    localparam logic [31:0] T3_LIT = 32'h4B80_0001;
`endif
    localparam int MW = 25 + XB;

    logic        clk = 1'b0;
    logic        rst, start, op;
    logic [31:0] a, b, result;
    logic        busy, done, overflow, underflow;

    int n_vec = 0;
    int n_err = 0;
    logic [33:0] exp_q[$];
    logic [33:0] cmp_e;

    fp_addsub_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    // Drop d bits off the bottom; with rounding, any lost 1 lands in bit 0.
    function automatic longint shift_sticky(input longint m, input int d);
        longint r;
        if (d > 26) return (RN && m != 0) ? 64'd1 : 64'd0;
        r = m >> d;
        if (RN && (m & ((64'd1 << d) - 1)) != 0) r = r | 64'd1;
        return r;
    endfunction

    // Value-level model: returns {overflow, underflow, result}.
    function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y, input logic sub);
        longint ma, mb, mr, keep, rem, half;
        int     ea, eb, er;
        logic   sa, sb, sr, up;
        logic [7:0] e8;
        sa = x[31];
        sb = y[31] ^ sub;
        ea = int'(x[30:23]);
        eb = int'(y[30:23]);
        ma = (ea == 0) ? 64'd0 : (longint'({1'b1, x[22:0]}) << XB);
        mb = (eb == 0) ? 64'd0 : (longint'({1'b1, y[22:0]}) << XB);
        if (ea < eb) begin ma = shift_sticky(ma, eb - ea); er = eb; end
        else         begin mb = shift_sticky(mb, ea - eb); er = ea; end
        if (sa == sb)     begin mr = ma + mb; sr = sa;   end
        else if (ma > mb) begin mr = ma - mb; sr = sa;   end
        else if (mb > ma) begin mr = mb - ma; sr = sb;   end
        else              begin mr = 0;       sr = 1'b0; end
        if (mr == 0) return {2'b00, sa & sb, 31'd0};
        if (mr >= (64'd1 << (MW - 1))) begin
            if (er + 1 >= 255) return {2'b10, sr, 8'hFF, 23'd0};
            mr = RN ? ((mr >> 1) | (mr & 64'd1)) : (mr >> 1);
            er = er + 1;
        end
        while (mr < (64'd1 << (MW - 2))) begin
            if (er > 1) begin mr = mr << 1; er = er - 1; end
            else return {2'b01, 32'd0};
        end
        keep = mr >> XB;
        rem  = mr & ((64'd1 << XB) - 1);
        half = 64'd1 << (XB - 1);
        up   = RN && ((rem > half) || (rem == half && keep[0]));
        if (up) keep = keep + 1;
        if (keep >= (64'd1 << 24)) begin
            keep = keep >> 1;
            if (er + 1 >= 255) return {2'b10, sr, 8'hFF, 23'd0};
            er = er + 1;
        end
        e8 = er[7:0];
        return {2'b00, sr, e8, keep[22:0]};
    endfunction

    // Compare process: every done pulse is checked against the model queue.
    always @(negedge clk) begin
        if (!rst && done) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_done: got result=%h ovf=%b unf=%b, required no done", result, overflow, underflow);
            end else begin
                cmp_e = exp_q.pop_front();
                if ({overflow, underflow, result} !== cmp_e) begin
                    n_err++;
                    $display("FAIL model_check: got ovf=%b unf=%b result=%h, required ovf=%b unf=%b result=%h",
                             overflow, underflow, result, cmp_e[33], cmp_e[32], cmp_e[31:0]);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] req);
        n_vec++;
        if (got !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", nm, got, req);
        end
    endtask

    task automatic wait_done(input string nm);
        int cyc;
        cyc = 0;
        while (done !== 1'b1 && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        if (done !== 1'b1) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: got no done in %0d cycles, required done", nm, cyc);
            exp_q.delete();
        end
    endtask

    task automatic apply(input logic [31:0] ta, input logic [31:0] tbv, input logic top,
                         input logic [31:0] lit, input logic lovf, input logic lunf, input string nm);
        @(negedge clk);
        a = ta; b = tbv; op = top; start = 1'b1;
        exp_q.push_back(model(ta, tbv, top));
        check({nm, "_model_pin"}, 64'(model(ta, tbv, top)), 64'({lovf, lunf, lit}));
        @(negedge clk);
        start = 1'b0;
        wait_done(nm);
        check(nm, 64'({overflow, underflow, result}), 64'({lovf, lunf, lit}));
        @(negedge clk);
        check({nm, "_done_once"}, 64'(done), 64'd0);
    endtask

    task automatic no_done_window(input string nm, input int cycles);
        int cnt;
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done === 1'b1) cnt++;
        end
        check(nm, 64'(cnt), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("reset_state", 64'({busy, done, overflow, underflow, result}), 64'd0);
        rst = 1'b0;

        apply(32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 1'b0, 1'b0, "one_plus_one");
        apply(32'h3FC0_0000, 32'h3F00_0000, 1'b1, 32'h3F80_0000, 1'b0, 1'b0, "sub_1p5_0p5");
        apply(32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000, 1'b0, 1'b0, "sub_equal");
        apply(32'h4B80_0000, 32'h4040_0000, 1'b0, T3_LIT,        1'b0, 1'b0, "round_tie");
        apply(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 1'b1, 1'b0, "overflow_pos");
        apply(32'h0080_0000, 32'h8080_0001, 1'b0, 32'h0000_0000, 1'b0, 1'b1, "underflow");
        apply(32'h3F80_0000, 32'h0000_0000, 1'b0, 32'h3F80_0000, 1'b0, 1'b0, "plus_zero");
        apply(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, 1'b0, 1'b0, "neg_zeros");
        apply(32'h3F80_0000, 32'hBFC0_0000, 1'b0, 32'hBF00_0000, 1'b0, 1'b0, "neg_result");
        apply(32'h3F80_0000, 32'h3080_0000, 1'b0, 32'h3F80_0000, 1'b0, 1'b0, "far_exit");
        apply(32'h3F80_0000, 32'h3300_0000, 1'b1, 32'h3F80_0000, 1'b0, 1'b0, "near_far_sub");
        apply(32'h3F80_0000, 32'h3F7F_FFFF, 1'b1, 32'h3380_0000, 1'b0, 1'b0, "deep_norm");
        apply(32'hFF7F_FFFF, 32'hFF7F_FFFF, 1'b0, 32'hFF80_0000, 1'b1, 1'b0, "overflow_neg");
        apply(32'h7E80_0000, 32'h7E80_0000, 1'b0, 32'h7F00_0000, 1'b0, 1'b0, "top_exp");
        apply(32'h8000_0000, 32'h0000_0000, 1'b1, 32'h8000_0000, 1'b0, 1'b0, "negz_minus_z");

        // start while busy is ignored
        @(negedge clk);
        a = 32'h3FC0_0000; b = 32'h3F00_0000; op = 1'b1; start = 1'b1;
        exp_q.push_back(model(32'h3FC0_0000, 32'h3F00_0000, 1'b1));
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 32'h7F7F_FFFF; b = 32'h7F7F_FFFF; op = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_ignore");
        check("busy_ignore", 64'({overflow, underflow, result}), 64'({2'b00, 32'h3F80_0000}));
        no_done_window("busy_ignore_no_second", 70);

        // reset in the middle of ALIGN aborts without done
        @(negedge clk);
        a = 32'h4B80_0000; b = 32'h4040_0000; op = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("busy_mid_align", 64'(busy), 64'd1);
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("abort_outputs", 64'({busy, done, overflow, underflow, result}), 64'd0);
        @(negedge clk);
        check("start_with_rst_ignored", 64'(busy), 64'd0);
        no_done_window("abort_no_done", 70);

        apply(32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 1'b0, 1'b0, "after_abort");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
